// File: rtl/dds_quadrature_qwave.sv
// Quadrature DDS core. A phase accumulator plus a per-cycle offset is folded
// into quarter-wave table addresses for sine and cosine. Sign and zero flags
// ride a delay line matched to the external ROM latency, then stage C turns
// magnitudes into signed samples.
module dds_quadrature_qwave #(
   parameter int PHASE_WIDTH   = 16,
   parameter int ADDRESS_WIDTH = 8,
   parameter int VALUE_WIDTH   = 8,
   parameter int INITIAL_STEP  = 1,
   parameter int TABLE_DELAY   = 1,
   parameter int SET_MODE      = 0
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            SET,
   input  logic [PHASE_WIDTH-1:0]          step_in,
   input  logic [PHASE_WIDTH-1:0]          offset_in,
   input  logic                            ENABLE,
   output logic [ADDRESS_WIDTH-3:0]        sin_address,
   input  logic [VALUE_WIDTH-2:0]          sin_table_value,
   output logic [ADDRESS_WIDTH-3:0]        cos_address,
   input  logic [VALUE_WIDTH-2:0]          cos_table_value,
   output logic signed [VALUE_WIDTH-1:0]   sin_value,
   output logic signed [VALUE_WIDTH-1:0]   cos_value,
   output logic                            valid,
   output logic                            zero_address
);

   localparam int  QW           = ADDRESS_WIDTH - 2;
   localparam int  FILL_W       = 2 + TABLE_DELAY;
   localparam bit  CLEAR_ON_SET = (SET_MODE == 0);

   logic [PHASE_WIDTH-1:0]   acc;
   logic [PHASE_WIDTH-1:0]   step;
   logic [PHASE_WIDTH-1:0]   phase;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [1:0]               quad;
   logic [1:0]               quad_cos;
   logic [QW-1:0]            idx;
   logic                     unused_phase_lsbs;

   logic                     sin_neg_b;
   logic                     cos_neg_b;
   logic                     zero_b;
   logic [TABLE_DELAY-1:0]   sin_neg_d;
   logic [TABLE_DELAY-1:0]   cos_neg_d;
   logic [TABLE_DELAY-1:0]   zero_d;
   logic [FILL_W-1:0]        fill;
   logic [VALUE_WIDTH-1:0]   sin_mag;
   logic [VALUE_WIDTH-1:0]   cos_mag;

   // Offset phase and quadrant split; cosine is sine one quadrant ahead.
   always_comb begin
      phase    = acc + offset_in;
      addr     = phase[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
      quad     = addr[ADDRESS_WIDTH-1 -: 2];
      quad_cos = quad + 2'd1;
      idx      = addr[QW-1:0];
      sin_mag  = {1'b0, sin_table_value};
      cos_mag  = {1'b0, cos_table_value};
   end

   assign unused_phase_lsbs = ^phase[PHASE_WIDTH-ADDRESS_WIDTH-1:0];

   // Stage A: step register and phase accumulator.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         acc  <= '0;
         step <= PHASE_WIDTH'(INITIAL_STEP);
      end else begin
         if (SET) step <= step_in;
         if (SET && CLEAR_ON_SET) acc <= '0;
         else if (ENABLE)         acc <= acc + step;
      end
   end

   // Stage B: mirrored quarter-table addresses and their sign/zero flags.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sin_address <= '0;
         cos_address <= '0;
         sin_neg_b   <= 1'b0;
         cos_neg_b   <= 1'b0;
         zero_b      <= 1'b0;
      end else begin
         sin_address <= quad[0] ? ~idx : idx;
         cos_address <= quad_cos[0] ? ~idx : idx;
         sin_neg_b   <= quad[1];
         cos_neg_b   <= quad_cos[1];
         zero_b      <= (addr == '0);
      end
   end

   // Flag delay line so each flag meets the ROM data it belongs to.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sin_neg_d <= '0;
         cos_neg_d <= '0;
         zero_d    <= '0;
      end else begin
         sin_neg_d[0] <= sin_neg_b;
         cos_neg_d[0] <= cos_neg_b;
         zero_d[0]    <= zero_b;
         for (int k = 1; k < TABLE_DELAY; k++) begin
            sin_neg_d[k] <= sin_neg_d[k-1];
            cos_neg_d[k] <= cos_neg_d[k-1];
            zero_d[k]    <= zero_d[k-1];
         end
      end
   end

   // Stage C: apply sign to the ROM magnitude.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sin_value    <= '0;
         cos_value    <= '0;
         zero_address <= 1'b0;
      end else begin
         sin_value    <= sin_neg_d[TABLE_DELAY-1] ? -sin_mag : sin_mag;
         cos_value    <= cos_neg_d[TABLE_DELAY-1] ? -cos_mag : cos_mag;
         zero_address <= zero_d[TABLE_DELAY-1];
      end
   end

   // Fill tracker: valid once a fresh accumulator value has reached stage C.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                    fill <= '0;
      else if (SET && CLEAR_ON_SET)  fill <= '0;
      else                           fill <= {fill[FILL_W-2:0], 1'b1};
   end

   assign valid = fill[FILL_W-1];

endmodule

// File: tb/tb_dds_quadrature_qwave.sv
// Bench for dds_quadrature_qwave: one restart-mode and one phase-continuous
// instance share stimulus; each has its own one-cycle quarter-wave ROM.
// Expected samples come from a full-wave sine reference, not from the table.
module tb_dds_quadrature_qwave;

   localparam real PI = 3.14159265358979323846;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        SET;
   logic [15:0] step_in;
   logic [15:0] offset_in;
   logic        ENABLE;

   logic [5:0]        sa0, ca0, sa1, ca1;
   logic [6:0]        rs0, rc0, rs1, rc1;
   logic signed [7:0] sv0, cv0, sv1, cv1;
   logic              vl0, vl1, za0, za1;

   logic [6:0] tbl [64];

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_acc  [2];
   logic [15:0] m_step [2];
   int          m_b    [2];
   int          m_rom  [2];
   int          m_out  [2];
   int          m_cnt  [2];

   always #5 CLK = ~CLK;

   dds_quadrature_qwave #(.SET_MODE(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .SET(SET), .step_in(step_in),
      .offset_in(offset_in), .ENABLE(ENABLE),
      .sin_address(sa0), .sin_table_value(rs0),
      .cos_address(ca0), .cos_table_value(rc0),
      .sin_value(sv0), .cos_value(cv0), .valid(vl0), .zero_address(za0));

   dds_quadrature_qwave #(.SET_MODE(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .SET(SET), .step_in(step_in),
      .offset_in(offset_in), .ENABLE(ENABLE),
      .sin_address(sa1), .sin_table_value(rs1),
      .cos_address(ca1), .cos_table_value(rc1),
      .sin_value(sv1), .cos_value(cv1), .valid(vl1), .zero_address(za1));

   always @(posedge CLK) begin
      rs0 <= tbl[sa0];
      rc0 <= tbl[ca0];
      rs1 <= tbl[sa1];
      rc1 <= tbl[ca1];
   end

   function automatic int sref(input int a);
      real s;
      int  mag;
      s   = $sin((a + 0.5) * 2.0 * PI / 256.0);
      mag = $rtoi(127.0 * ((s < 0.0) ? -s : s) + 0.5);
      return (s < 0.0) ? -mag : mag;
   endfunction

   function automatic int fold(input int a);
      int q, i;
      q = (a / 64) % 4;
      i = a % 64;
      return (q % 2 == 1) ? (63 - i) : i;
   endfunction

   task automatic chk(input string tag, input int d, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_acc[d]  = '0;
         m_step[d] = 16'd1;
         m_b[d]    = 0;
         m_rom[d]  = 0;
         m_out[d]  = 0;
         m_cnt[d]  = 0;
      end
   endtask

   task automatic model_edge();
      logic [15:0] p;
      for (int d = 0; d < 2; d++) begin
         p        = m_acc[d] + offset_in;
         m_out[d] = m_rom[d];
         m_rom[d] = m_b[d];
         m_b[d]   = int'(p[15:8]);
         if (SET && d == 0) m_acc[d] = '0;
         else if (ENABLE)   m_acc[d] = m_acc[d] + m_step[d];
         if (SET) m_step[d] = step_in;
         if (SET && d == 0)    m_cnt[d] = 0;
         else if (m_cnt[d] < 3) m_cnt[d]++;
      end
   endtask

   task automatic check_dut(input int d, input logic [5:0] sa, input logic [5:0] ca,
                            input logic signed [7:0] sv, input logic signed [7:0] cv,
                            input logic vl, input logic za);
      chk("valid", d, int'(vl), (m_cnt[d] >= 3) ? 1 : 0);
      if (m_cnt[d] >= 1) begin
         chk("sin_address", d, int'(sa), fold(m_b[d]));
         chk("cos_address", d, int'(ca), fold((m_b[d] + 64) % 256));
      end
      if (m_cnt[d] >= 3) begin
         chk("sin_value", d, int'(sv), sref(m_out[d]));
         chk("cos_value", d, int'(cv), sref((m_out[d] + 64) % 256));
         chk("zero_address", d, int'(za), (m_out[d] == 0) ? 1 : 0);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sin_value"}, 0, int'(sv0), 0);
      chk({tag, "_cos_value"}, 0, int'(cv0), 0);
      chk({tag, "_valid"}, 0, int'(vl0), 0);
      chk({tag, "_zero"}, 0, int'(za0), 0);
      chk({tag, "_sin_address"}, 0, int'(sa0), 0);
      chk({tag, "_sin_value"}, 1, int'(sv1), 0);
      chk({tag, "_cos_value"}, 1, int'(cv1), 0);
      chk({tag, "_valid"}, 1, int'(vl1), 0);
      chk({tag, "_cos_address"}, 1, int'(ca1), 0);
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
      check_dut(0, sa0, ca0, sv0, cv0, vl0, za0);
      check_dut(1, sa1, ca1, sv1, cv1, vl1, za1);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      for (int k = 0; k < 64; k++)
         tbl[k] = 7'($rtoi(127.0 * $sin((k + 0.5) * PI / 128.0) + 0.5));

      RESET     = 1'b0;
      SET       = 1'b0;
      step_in   = '0;
      offset_in = '0;
      ENABLE    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");

      // restart with step 256: full sweep of all four quadrants plus wrap
      RESET   = 1'b1;
      model_reset();
      step_in = 16'd256;
      SET     = 1'b1;
      ENABLE  = 1'b1;
      tick();
      SET = 1'b0;
      run(300);

      // quarter-turn offset, then back to no offset
      offset_in = 16'h4000;
      run(80);
      offset_in = 16'h0000;
      run(20);

      // retune to 512 mid-run
      step_in = 16'd512;
      SET     = 1'b1;
      tick();
      SET = 1'b0;
      run(40);

      // freeze for 5 clocks, then resume
      ENABLE = 1'b0;
      run(5);
      ENABLE = 1'b1;
      run(10);

      // step 0 gives DC, then a near-full-scale step sweeps backwards
      step_in = 16'd0;
      SET     = 1'b1;
      tick();
      SET = 1'b0;
      run(8);
      step_in = 16'hFF00;
      SET     = 1'b1;
      tick();
      SET = 1'b0;
      run(20);

      // asynchronous reset between clock edges
      #3;
      RESET = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      #1;
      RESET = 1'b1;
      run(270);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
